// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per clock.
// The datapath works on operand magnitudes; sign correction and RISC-V corner cases are applied in FIX.
module mdu_iter #(
  parameter int XLEN = 32,
  parameter int CNTW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] wb_data,
  output logic [4:0]      wb_addr,
  output logic            wb_en
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(XLEN-1);

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              div0_q, div0_d;
  logic              ovf_q, ovf_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              wb_en_q, wb_en_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic [4:0]        wb_addr_q, wb_addr_d;

  logic              in_sa, in_sb;
  logic [XLEN-1:0]   in_abs_a, in_abs_b;

  // Sign flags for a new request: a flag is set only when the op treats that operand as signed
  always_comb begin
    in_sa = 1'b0;
    in_sb = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        in_sa = rs1_val[XLEN-1];
        in_sb = rs2_val[XLEN-1];
      end
      3'b010:  in_sa = rs1_val[XLEN-1];
      default: ;
    endcase
    in_abs_a = in_sa ? -rs1_val : rs1_val;
    in_abs_b = in_sb ? -rs2_val : rs2_val;
  end

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quo_signed, rem_signed, rs1_back, fix_res;

  // Product register holds {partial high, multiplier}; divide uses it as {remainder, dividend/quotient}
  always_comb begin
    mul_sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    div_trial   = prod_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    prod_signed = (sa_q ^ sb_q) ? -prod_q : prod_q;
    quo_signed  = (sa_q ^ sb_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_signed  = sa_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
    rs1_back    = sa_q ? -a_q : a_q;
    case (op_q)
      3'b000:                 fix_res = prod_signed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_signed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = div0_q ? '1 : (ovf_q ? MIN_NEG : quo_signed);
      default:                fix_res = div0_q ? rs1_back : (ovf_q ? '0 : rem_signed);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    prod_d    = prod_q;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_CALC;
          cnt_d   = '0;
          op_d    = funct3;
          rd_d    = rd_in;
          a_d     = in_abs_a;
          b_d     = in_abs_b;
          sa_d    = in_sa;
          sb_d    = in_sb;
          div0_d  = (rs2_val == '0);
          ovf_d   = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                    (rs1_val == MIN_NEG) && (&rs2_val);
          prod_d  = funct3[2] ? {{XLEN{1'b0}}, in_abs_a} : {{XLEN{1'b0}}, in_abs_b};
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) begin
            if (!div_trial[XLEN]) prod_d = {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
            else                  prod_d = {prod_q[2*XLEN-2:0], 1'b0};
          end else begin
            prod_d = {mul_sum, prod_q[XLEN-1:1]};
          end
          if (cnt_q == LAST_CNT) state_d = S_FIX;
          else                   cnt_d   = cnt_q + CNTW'(1);
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_DONE;
          wb_data_d = fix_res;
          wb_addr_d = rd_q;
          done_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    wb_en_d = done_d && (wb_addr_d != 5'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      prod_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      prod_q    <= prod_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wb_en_q   <= wb_en_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign wb_en   = wb_en_q;
  assign wb_data = wb_data_q;
  assign wb_addr = wb_addr_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed and randomized bench for mdu_iter; expected results come from 64-bit arithmetic
// following the RV32M rules, including divide-by-zero and signed-overflow results.
module tb_mdu_iter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_en;

  int vectors;
  int miscompares;

  mdu_iter #(.XLEN(32), .CNTW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .wb_data (wb_data),
    .wb_addr (wb_addr),
    .wb_en   (wb_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb;
        return p[31:0];
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called with busy=0, #1 after an edge; the next edge accepts the op
  task automatic apply_stimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] rd, input logic [31:0] expected,
                                input string tag);
    int cyc;
    start   = 1'b1;
    funct3  = f3;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    @(posedge clk); #1;
    start   = 1'b0;
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in   = 5'($urandom);
    funct3  = 3'($urandom);
    cyc = 1;
    check_output({tag, "_busy"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == 5) start = 1'b1;
      if (cyc == 6) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check_output({tag, "_latency"}, 32'(cyc), 32'd34);
    check_output({tag, "_data"}, wb_data, expected);
    check_output({tag, "_addr"}, 32'(wb_addr), 32'(rd));
    check_output({tag, "_wben"}, 32'(wb_en), 32'(rd != 5'd0));
    @(posedge clk); #1;
    check_output({tag, "_done_drop"}, 32'(done), 32'd0);
    check_output({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          done_cnt, consec, first_i, second_i, wait_cyc;
    logic        prev_done;
    logic [31:0] first_data;

    vectors     = 0;
    miscompares = 0;
    rst     = 1'b0;
    start   = 1'b0;
    funct3  = 3'b000;
    rs1_val = 32'd0;
    rs2_val = 32'd0;
    rd_in   = 5'd0;
    flush   = 1'b0;

    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_wben", 32'(wb_en), 32'd0);
    check_output("rst_data", wb_data, 32'd0);
    check_output("rst_addr", 32'(wb_addr), 32'd0);
    rst = 1'b0;

    $display("[TB] directed operations");
    apply_stimulus(3'b000, 32'hFFFF_FFFF, 32'h0000_0003, 5'd5, 32'hFFFF_FFFD, "mul");
    apply_stimulus(3'b001, 32'hFFFF_FFFF, 32'h0000_0003, 5'd5, 32'hFFFF_FFFF, "mulh");
    apply_stimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, "mulhu");
    apply_stimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, "mulhsu");
    apply_stimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFD, "div");
    apply_stimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFF, "rem");
    apply_stimulus(3'b101, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'h7FFF_FFFC, "divu");
    apply_stimulus(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'h0000_0001, "remu");
    apply_stimulus(3'b100, 32'h0000_0055, 32'd0, 5'd12, 32'hFFFF_FFFF, "div_by0");
    apply_stimulus(3'b110, 32'h0000_1234, 32'd0, 5'd13, 32'h0000_1234, "rem_by0");
    apply_stimulus(3'b110, 32'hFFFF_FF00, 32'd0, 5'd13, 32'hFFFF_FF00, "rem_neg_by0");
    apply_stimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, "div_ovf");
    apply_stimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0000_0000, "rem_ovf");
    apply_stimulus(3'b000, 32'd6, 32'd7, 5'd0, 32'd42, "rd_zero");

    $display("[TB] randomized operations");
    for (int k = 0; k < 24; k++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (k % 5 == 1) b = 32'd0;
      if (k % 6 == 2) b = 32'($urandom_range(1, 15));
      if (k % 7 == 3) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      rd = 5'($urandom);
      apply_stimulus(f3, a, b, rd, ref_model(f3, a, b), "rand");
    end

    $display("[TB] start held high");
    start     = 1'b1;
    funct3    = 3'b000;
    rs1_val   = 32'd3;
    rs2_val   = 32'd4;
    rd_in     = 5'd7;
    done_cnt  = 0;
    consec    = 0;
    first_i   = 0;
    second_i  = 0;
    prev_done = 1'b0;
    first_data = 32'd0;
    for (int i = 1; i <= 110; i++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (prev_done) consec++;
        if (done_cnt == 1) begin
          first_i    = i;
          first_data = wb_data;
        end
        if (done_cnt == 2) second_i = i;
      end
      prev_done = done;
    end
    start = 1'b0;
    check_output("held_done_count", 32'(done_cnt), 32'd3);
    check_output("held_first_cycle", 32'(first_i), 32'd34);
    check_output("held_spacing", 32'(second_i - first_i), 32'd35);
    check_output("held_consecutive", 32'(consec), 32'd0);
    check_output("held_data", first_data, 32'd12);
    wait_cyc = 0;
    while (busy && wait_cyc < 60) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    check_output("held_drain", 32'(busy), 32'd0);

    $display("[TB] flush behaviour");
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    check_output("flush_idle_priority", 32'(busy), 32'd0);

    start   = 1'b1;
    funct3  = 3'b100;
    rs1_val = 32'd1000;
    rs2_val = 32'd3;
    rd_in   = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    wait_cyc = 1;
    while (wait_cyc < 10) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_output("flush_busy", 32'(busy), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check_output("flush_no_done", 32'(done_cnt), 32'd0);

    $display("[TB] asynchronous reset mid-operation");
    start   = 1'b1;
    funct3  = 3'b101;
    rs1_val = 32'd500;
    rs2_val = 32'd9;
    rd_in   = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    check_output("arst_busy", 32'(busy), 32'd0);
    check_output("arst_done", 32'(done), 32'd0);
    check_output("arst_wben", 32'(wb_en), 32'd0);
    check_output("arst_data", wb_data, 32'd0);
    check_output("arst_addr", 32'(wb_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply_stimulus(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
